// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request, move-to and result signals of the multiply/divide unit
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mt_hi, mt_lo, write_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mt_hi, mt_lo, write_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic        neg_a;
    logic        neg_b;
    logic        b_zero;
    // Multiplicand for multiply, divisor for divide; both held as magnitudes.
    logic [31:0] other;
    // p_hi: partial product high / running remainder.
    // p_lo: multiplier being shifted out / dividend shifted out while quotient shifts in.
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    logic        is_div;
    logic        res_neg;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_neg;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign is_div   = op_q[1];
    assign res_neg  = neg_a ^ neg_b;
    assign bus.busy = (state != IDLE);

    // Operand magnitudes; signs only matter for the signed ops (op[0] = 1).
    assign in_mag_a = (bus.op[0] && bus.operand_a[31]) ? 32'd0 - bus.operand_a : bus.operand_a;
    assign in_mag_b = (bus.op[0] && bus.operand_b[31]) ? 32'd0 - bus.operand_b : bus.operand_b;

    // One iteration of shift-add and restoring shift-subtract, plus sign correction for FIX.
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, other} : 33'd0);
        div_shift = {p_hi, p_lo[31]};
        div_diff  = div_shift - {1'b0, other};
        div_ge    = (div_shift >= {1'b0, other});
        prod_neg  = 64'd0 - {p_hi, p_lo};
        if (is_div) begin
            // Divide by zero leaves the dividend magnitude in p_hi, so the usual
            // remainder sign fix restores OperandA; only the quotient is forced.
            fix_hi = neg_a ? 32'd0 - p_hi : p_hi;
            fix_lo = b_zero ? 32'hFFFF_FFFF : (res_neg ? 32'd0 - p_lo : p_lo);
        end else begin
            fix_hi = res_neg ? prod_neg[63:32] : p_hi;
            fix_lo = res_neg ? prod_neg[31:0]  : p_lo;
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 6'd0;
            op_q            <= 2'd0;
            neg_a           <= 1'b0;
            neg_b           <= 1'b0;
            b_zero          <= 1'b0;
            other           <= 32'd0;
            p_hi            <= 32'd0;
            p_lo            <= 32'd0;
            bus.hi          <= 32'd0;
            bus.lo          <= 32'd0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Start wins over any simultaneous move to HI/LO.
                        op_q   <= bus.op;
                        neg_a  <= bus.op[0] & bus.operand_a[31];
                        neg_b  <= bus.op[0] & bus.operand_b[31];
                        b_zero <= (bus.operand_b == 32'd0);
                        other  <= bus.op[1] ? in_mag_b : in_mag_a;
                        p_lo   <= bus.op[1] ? in_mag_a : in_mag_b;
                        p_hi   <= 32'd0;
                        cnt    <= 6'd0;
                        state  <= RUN;
                    end else begin
                        if (bus.mt_hi) bus.hi <= bus.write_data;
                        if (bus.mt_lo) bus.lo <= bus.write_data;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        p_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                        p_lo <= {p_lo[30:0], div_ge};
                    end else begin
                        p_hi <= mul_sum[32:1];
                        p_lo <= {mul_sum[0], p_lo[31:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    bus.hi          <= fix_hi;
                    bus.lo          <= fix_lo;
                    bus.done        <= 1'b1;
                    bus.div_by_zero <= is_div & b_zero;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic clk;
    logic rst;
    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.operand_a  = 32'd0;
        bus.operand_b  = 32'd0;
        bus.mt_hi      = 1'b0;
        bus.mt_lo      = 1'b0;
        bus.write_data = 32'd0;
    endtask

    // Called just after a negedge; leaves us half a cycle after the capturing edge k.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        drive_idle();
    endtask

    // Walks edges k+1..k+33; optional disturbance (start, operand change, MTHI) at one cycle.
    task automatic wait_result(input string name, input int disturb,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dbz);
        int bad;
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (i == disturb) begin
                bus.start      = 1'b1;
                bus.op         = 2'd3;
                bus.operand_a  = 32'hDEAD_BEEF;
                bus.operand_b  = 32'h0000_0000;
                bus.mt_hi      = 1'b1;
                bus.write_data = 32'h0000_1234;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        drive_idle();
        @(negedge clk);
        check({name, " busy-during-run errors"}, 64'(bad), 64'd0);
        check({name, " done/busy at k+33"}, {62'd0, bus.done, bus.busy}, 64'd2);
        check({name, " hi/lo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        check({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'd0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[6]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[7]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'd3, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[11] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy/done/dbz", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);

        // Moves to HI/LO in IDLE
        bus.mt_lo = 1'b1;
        bus.write_data = 32'hCAFE_0001;
        @(negedge clk);
        drive_idle();
        check("mtlo", {bus.hi, bus.lo}, {32'h0, 32'hCAFE_0001});
        bus.mt_hi = 1'b1;
        bus.mt_lo = 1'b1;
        bus.write_data = 32'h0000_AAAA;
        @(negedge clk);
        drive_idle();
        check("mthi+mtlo", {bus.hi, bus.lo}, {32'h0000_AAAA, 32'h0000_AAAA});

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), 0, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
            @(negedge clk);
            check($sformatf("vec%0d single done pulse", i), {62'd0, bus.done, bus.div_by_zero}, 64'd0);
        end

        // Start and MTHI mid-run are ignored; start in the done cycle is accepted
        start_op(2'd0, 32'd3, 32'd5);
        wait_result("busy-ignore", 5, 32'd0, 32'd15, 1'b0);
        start_op(2'd0, 32'd2, 32'd3);
        check("start-in-done accepted", 64'(bus.busy), 64'd1);
        wait_result("back-to-back", 0, 32'd0, 32'd6, 1'b0);

        // Reset during a DIVU aborts with no write-back
        @(negedge clk);
        start_op(2'd2, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("no done after abort", 64'(done_cnt), 64'd0);

        // Start together with MTHI: move dropped, HI only changed by the result
        bus.mt_hi = 1'b1;
        bus.write_data = 32'h0000_0077;
        @(negedge clk);
        drive_idle();
        check("mthi before start", 64'(bus.hi), 64'h77);
        bus.mt_hi = 1'b1;
        bus.write_data = 32'h0000_DEAD;
        start_op(2'd0, 32'h0001_0000, 32'h0003_0000);
        check("start wins over mthi", 64'(bus.hi), 64'h77);
        wait_result("start+mthi", 0, 32'h0000_0003, 32'h0000_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
